// File: rtl/demux1x8_deser.sv
// Serial-to-parallel receiver: routes each sampled bit to a lane via a 1xN demux and
// hands completed N-bit words to the consumer over a valid/ready handshake.
module demux1x8_deser #(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     lane,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

    localparam logic [SEL_W-1:0] SelLast = SEL_W'(N - 1);

    out_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     lane_q, lane_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             overrun_q, overrun_d;

    logic             complete;
    logic [N-1:0]     word;

    // A word completes only on an ordinary (non-sof) bit landing in the last lane.
    assign complete = din_valid && !sof && (sel_q == SelLast);
    assign word     = {din, lane_q[N-2:0]};

    always_comb begin
        sel_d  = sel_q;
        lane_d = lane_q;
        if (sof) begin
            if (din_valid) begin
                lane_d    = '0;
                lane_d[0] = din;
                sel_d     = SEL_W'(1);
            end else begin
                sel_d = '0;
            end
        end else if (din_valid) begin
            lane_d[sel_q] = din;
            sel_d         = sel_q + SEL_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    dout_d  = word;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (dout_ready) begin
                    if (complete) begin
                        dout_d = word;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (complete) begin
                    // Consumer still holds the old word: drop the new one; set beats clear.
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StEmpty;
            sel_q     <= '0;
            lane_q    <= '0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lane_q    <= lane_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
        end
    end

    assign sel        = sel_q;
    assign lane       = lane_q;
    assign dout       = dout_q;
    assign dout_valid = (state_q == StFull);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux1x8_deser.sv
// Directed bench for demux1x8_deser: inputs change on the falling edge, outputs are
// sampled on the falling edge, so every check sees settled registered values.
module tb_demux1x8_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [2:0] sel;
    logic [7:0] lane;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;
    logic       ovr_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    demux1x8_deser #(
        .N    (8),
        .SEL_W(3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .sel       (sel),
        .lane      (lane),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one word LSB first on consecutive cycles; returns with din_valid low on the
    // falling edge right after the 8th bit was sampled.
    task automatic send_word(input logic [7:0] w, input bit use_sof);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            din       = w[k];
            din_valid = 1'b1;
            sof       = use_sof && (k == 0);
        end
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        int         g;

        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        sof        = 1'b0;
        dout_ready = 1'b1;
        ovr_clr    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_lane", 32'(lane), 32'h0);
        check_eq("rst_dout", 32'(dout), 32'h0);
        check_eq("rst_valid", 32'(dout_valid), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;

        // Basic frame, bits 0,1,0,1,1,0,0,0 -> 0x1A.
        send_word(8'h1A, 1'b1);
        check_eq("t1_dout", 32'(dout), 32'h1A);
        check_eq("t1_valid", 32'(dout_valid), 32'h1);
        check_eq("t1_sel", 32'(sel), 32'h0);
        check_eq("t1_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(dout_valid), 32'h0);

        // Back-to-back frames 0x10 then 0x0F with continuous din_valid.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            check_eq("t2_valid", 32'(dout_valid), (i == 8 || i == 16) ? 32'h1 : 32'h0);
            if (i == 8) check_eq("t2_dout0", 32'(dout), 32'h10);
            if (i == 16) check_eq("t2_dout1", 32'(dout), 32'h0F);
            if (i < 16) begin
                w         = (i < 8) ? 8'h10 : 8'h0F;
                din       = w[i % 8];
                din_valid = 1'b1;
                sof       = (i == 0);
            end else begin
                din_valid = 1'b0;
                sof       = 1'b0;
            end
        end
        check_eq("t2_lane", 32'(lane), 32'h0F);
        check_eq("t2_ovr", 32'(overrun), 32'h0);

        // Backpressure across two frames -> overrun, then drain and clear.
        @(negedge clk);
        dout_ready = 1'b0;
        send_word(8'h1A, 1'b1);
        check_eq("t3_dout_a", 32'(dout), 32'h1A);
        check_eq("t3_valid_a", 32'(dout_valid), 32'h1);
        check_eq("t3_ovr_a", 32'(overrun), 32'h0);
        send_word(8'hFF, 1'b1);
        check_eq("t3_dout_b", 32'(dout), 32'h1A);
        check_eq("t3_valid_b", 32'(dout_valid), 32'h1);
        check_eq("t3_ovr_b", 32'(overrun), 32'h1);
        check_eq("t3_lane", 32'(lane), 32'hFF);
        dout_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_valid_c", 32'(dout_valid), 32'h0);
        check_eq("t3_ovr_sticky", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check_eq("t3_ovr_clr", 32'(overrun), 32'h0);

        // Partial frame of 3 bits abandoned by a new sof.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            din       = 1'b1;
            din_valid = 1'b1;
            sof       = (k == 0);
        end
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
        check_eq("t4_sel_partial", 32'(sel), 32'h3);
        check_eq("t4_lane_partial", 32'(lane), 32'h07);
        send_word(8'h0F, 1'b1);
        check_eq("t4_dout", 32'(dout), 32'h0F);
        check_eq("t4_valid", 32'(dout_valid), 32'h1);
        check_eq("t4_ovr", 32'(overrun), 32'h0);
        check_eq("t4_lane", 32'(lane), 32'h0F);

        // 0x1A with random gaps of 1..4 idle cycles between bits.
        w = 8'h1A;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            din       = w[k];
            din_valid = 1'b1;
            sof       = (k == 0);
            if (k < 7) begin
                g = $urandom_range(4, 1);
                for (int j = 0; j < g; j++) begin
                    @(negedge clk);
                    din_valid = 1'b0;
                    sof       = 1'b0;
                    check_eq("t5_sel_hold", 32'(sel), 32'(k + 1));
                    check_eq("t5_valid_gap", 32'(dout_valid), 32'h0);
                end
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
        check_eq("t5_dout", 32'(dout), 32'h1A);
        check_eq("t5_valid", 32'(dout_valid), 32'h1);
        check_eq("t5_sel", 32'(sel), 32'h0);

        // Asynchronous reset between edges after 5 bits, then a frame without sof.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din       = 1'b1;
            din_valid = 1'b1;
            sof       = (k == 0);
        end
        @(posedge clk);
        #2;
        check_eq("t6_sel_pre", 32'(sel), 32'h5);
        rst = 1'b1;
        #1;
        check_eq("t6_sel", 32'(sel), 32'h0);
        check_eq("t6_lane", 32'(lane), 32'h0);
        check_eq("t6_dout", 32'(dout), 32'h0);
        check_eq("t6_valid", 32'(dout_valid), 32'h0);
        check_eq("t6_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
        rst       = 1'b0;
        send_word(8'h10, 1'b0);
        check_eq("t6_dout_after", 32'(dout), 32'h10);
        check_eq("t6_valid_after", 32'(dout_valid), 32'h1);
        check_eq("t6_lane_after", 32'(lane), 32'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/demux1x8_deser.md
Name: demux1x8_deser

Overview:
- Receive-side counterpart of the 8x1 mux path. The mux path walks a 3-bit select (s[0] toggles fastest) over i[7:0] and emits one bit per select step.
- This block samples that serial bit stream and routes each bit to a registered output lane with a 1x8 demultiplexer. The routing is driven by its own select counter.
- After each completed group of 8 bits it presents the assembled word with a valid/ready handshake.
- It sits directly after the mux/serial path in the datapath.

Parameters:
- N, 8, number of lanes and word width. Must be a power of two, N >= 2.
- SEL_W, 3, select counter width. Equals log2(N).

Ports:
- clk, input, 1, single clock. All logic is rising-edge.
- rst, input, 1, asynchronous, active-high reset.
- din, input, 1, serial data bit (the mux output y).
- din_valid, input, 1, din is sampled on this clock edge.
- sof, input, 1, start of frame. The bit presented with it belongs to lane 0.
- sel, output, SEL_W, current demux select (next lane to be written).
- lane, output, N, registered demux outputs. lane[k] holds the last bit routed to select k.
- dout, output, N, assembled word. Bit k = bit received at select k.
- dout_valid, output, 1, dout holds an unconsumed word.
- dout_ready, input, 1, consumer accepts dout on an edge where dout_valid=1.
- overrun, output, 1, sticky flag: a completed word was dropped.
- ovr_clr, input, 1, synchronous clear of overrun.

Behaviour:
- Reset (async, immediate): sel=0, lane=0, dout=0, dout_valid=0, overrun=0. Reset is asserted asynchronously and released synchronously to clk.
- Reset mid-frame discards the partial word. The first din_valid after release writes lane[0].
- Select counter:
  - On an edge with din_valid=1 and sof=0: lane[sel] <= din; sel <= sel+1, wrapping N-1 -> 0.
  - din_valid=0: sel and lane hold. Gaps of any length between bits are legal.
- sof handling:
  - sof=1 and din_valid=1: lane[0] <= din, lane[N-1:1] <= 0, sel <= 1. Any partial word is discarded with no flag.
  - sof=1 and din_valid=0: sel <= 0, lanes unchanged, partial word discarded.
  - sof on an edge where sel=N-1 does not complete a word.
- Word completion: occurs on an edge with din_valid=1, sof=0 and sel=N-1. The completed word is {din, lane[N-2:0]}.
- Latency: dout and dout_valid update on the same edge that samples the Nth bit. They are visible one cycle after the bit is presented.
- Output state machine (two states):
  - EMPTY (dout_valid=0): completion loads dout, sets dout_valid=1 -> FULL.
  - FULL (dout_valid=1): dout is held stable.
    - dout_ready=1 with no completion -> dout_valid=0, EMPTY.
    - dout_ready=1 with completion on the same edge -> dout loads the new word, dout_valid stays 1 (no bubble, no overrun).
    - dout_ready=0 with completion -> new word dropped, dout unchanged, overrun <= 1.
  - dout_ready is ignored in EMPTY.
- overrun: set as above; cleared only by rst or ovr_clr=1.
  - If set and clear occur on the same edge, set wins.
- lane keeps its last values after a word completes. lane is not cleared on completion.
- Sustained input: with din_valid=1 every cycle and dout_ready=1, a word is produced every N cycles indefinitely.
- No combinational path from any input to any output. All outputs are registers.

Test Plan:
- Reset then bits 0,1,0,1,1,0,0,0 on 8 consecutive cycles (din_valid=1, sof=1 on the first), dout_ready=1 -> dout=8'h1A, dout_valid=1 for exactly 1 cycle, sel=0 afterwards, overrun=0.
- Back-to-back frames: 8'h10 then 8'h0F, din_valid continuous, dout_ready=1 -> dout_valid pulses 8 cycles apart with 8'h10 then 8'h0F. lane=8'h0F at the end.
- Hold dout_ready=0 across two frames (8'h1A then 8'hFF) -> dout stays 8'h1A, overrun=1 after the second frame's 8th bit. Then dout_ready=1 -> dout_valid=0 next cycle. Then ovr_clr=1 -> overrun=0.
- Send 3 bits of a frame, then sof with bits of 8'h0F -> dout=8'h0F. The partial word is dropped silently, overrun=0.
- Send 8'h1A with din_valid deasserted for 1-4 random cycles between bits -> dout=8'h1A. sel holds during the gaps.
- Assert rst asynchronously (between clock edges) after 5 bits -> all outputs 0 immediately. The next full frame 8'h10 is received correctly.
